// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: per-register enable/flush generation for the
// fd/de/em/mw pipeline registers, memory-wait timeout FSM, mult/div occupancy
// tracking and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int unsigned MULDIV_LATENCY = 32,
  parameter int unsigned MEM_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg_addr,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_en,
  output logic        de_flush,
  output logic        em_en,
  output logic        mw_en,
  output logic        mw_bubble,
  output logic        muldiv_start,
  output logic        muldiv_busy,
  output logic        mem_error,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic [7:0]  muldiv_cnt;
  logic        mem_error_next;
  logic        load_use, md_hz, freeze;

  assign muldiv_busy = (muldiv_cnt != '0);

  // Combinational hazard detection
  always_comb begin
    load_use = ex_mem_read && ex_reg_write && (ex_write_reg_addr != '0) &&
               ((id_uses_rs && (id_rs_addr == ex_write_reg_addr)) ||
                (id_uses_rt && (id_rt_addr == ex_write_reg_addr)));
    md_hz    = muldiv_busy && (id_is_muldiv || id_reads_hilo);
    freeze   = (state == HALT) || (mem_req && !mem_ready);
  end

  // FSM state register with wait counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_error <= mem_error_next;
    end
  end

  // Next-state logic: memory wait tracking and timeout detection
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    mem_error_next = mem_error;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || !mem_req) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == 16'(MEM_TIMEOUT - 1)) begin
          state_next     = HALT;
          mem_error_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      HALT: begin
        mem_error_next = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Output logic: prioritised enable/flush generation
  always_comb begin
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    fd_flush     = 1'b0;
    de_en        = 1'b1;
    de_flush     = 1'b0;
    em_en        = 1'b1;
    mw_en        = 1'b1;
    mw_bubble    = 1'b0;
    muldiv_start = 1'b0;
    if (!rst) begin
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      mw_bubble = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      mw_en     = (state != HALT);
      mw_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use || md_hz) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end else begin
      muldiv_start = id_is_muldiv && !muldiv_busy;
    end
  end

  // Mult/div occupancy countdown and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      muldiv_cnt   <= '0;
      stall_cycles <= '0;
    end else begin
      if (muldiv_start)
        muldiv_cnt <= 8'(MULDIV_LATENCY);
      else if (muldiv_busy)
        muldiv_cnt <= muldiv_cnt - 8'd1;
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a reference model predicts
// each cycle's outputs when stimulus is applied; a monitor compares at negedge.
module tb_pipeline_hazard_controller;

  localparam int unsigned LAT = 4;
  localparam int unsigned TO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_write_reg_addr;
  logic        id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo;
  logic        ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_bubble;
  logic        muldiv_start, muldiv_busy, mem_error;
  logic [31:0] stall_cycles;

  pipeline_hazard_controller #(.MULDIV_LATENCY(LAT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg_addr(ex_write_reg_addr), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
    .de_flush(de_flush), .em_en(em_en), .mw_en(mw_en), .mw_bubble(mw_bubble),
    .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
    .mem_error(mem_error), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_bubble;
    logic        start, busy, err;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: 0 = run, 1 = waiting on memory, 2 = halted
  int     m_state, m_wait, m_md;
  bit     m_err;
  longint m_stall;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit lu, mdh, frz;
    e = '0;
    e.busy  = (m_md != 0);
    e.err   = m_err;
    e.stall = 32'(m_stall);
    {e.pc_en, e.fd_en, e.de_en, e.em_en, e.mw_en} = '1;
    if (!rst) begin
      e.fd_flush = 1; e.de_flush = 1; e.mw_bubble = 1;
      return e;
    end
    lu  = ex_mem_read && ex_reg_write && ex_write_reg_addr != 0 &&
          ((id_uses_rs && id_rs_addr == ex_write_reg_addr) ||
           (id_uses_rt && id_rt_addr == ex_write_reg_addr));
    mdh = e.busy && (id_is_muldiv || id_reads_hilo);
    frz = (m_state == 2) || (mem_req && !mem_ready);
    if (frz) begin
      {e.pc_en, e.fd_en, e.de_en, e.em_en} = '0;
      e.mw_en     = (m_state != 2);
      e.mw_bubble = 1;
    end else if (ex_branch_taken) begin
      e.fd_flush = 1; e.de_flush = 1;
    end else if (lu || mdh) begin
      e.pc_en = 0; e.fd_en = 0; e.de_flush = 1;
    end else begin
      e.start = id_is_muldiv && !e.busy;
    end
    return e;
  endfunction

  // Advance the model across a clock edge using the inputs held over that edge
  task automatic model_tick(input exp_t e);
    if (!rst) begin
      m_state = 0; m_wait = 0; m_md = 0; m_err = 0; m_stall = 0;
      return;
    end
    if (e.start) m_md = LAT;
    else if (m_md > 0) m_md--;
    if (!e.pc_en && m_stall < 64'hFFFF_FFFF) m_stall++;
    case (m_state)
      0: if (mem_req && !mem_ready) begin m_state = 1; m_wait = 1; end
      1: if (mem_ready || !mem_req) begin m_state = 0; m_wait = 0; end
         else if (m_wait == TO - 1) begin m_state = 2; m_err = 1; end
         else m_wait++;
      default: m_err = 1;
    endcase
  endtask

  task automatic apply(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit md, input bit hilo,
                       input bit exr, input bit exw, input logic [4:0] exa,
                       input bit br, input bit mq, input bit mr);
    @(posedge clk);
    model_tick(last);
    #1;
    rst = r; id_rs_addr = rs; id_rt_addr = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_muldiv = md; id_reads_hilo = hilo; ex_mem_read = exr; ex_reg_write = exw;
    ex_write_reg_addr = exa; ex_branch_taken = br; mem_req = mq; mem_ready = mr;
    last = model_out();
    q.push_back(last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mem(input bit mq, input bit mr);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mq, mr);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_eq("pc_en",        32'(pc_en),        32'(e.pc_en));
      check_eq("fd_en",        32'(fd_en),        32'(e.fd_en));
      check_eq("fd_flush",     32'(fd_flush),     32'(e.fd_flush));
      check_eq("de_en",        32'(de_en),        32'(e.de_en));
      check_eq("de_flush",     32'(de_flush),     32'(e.de_flush));
      check_eq("em_en",        32'(em_en),        32'(e.em_en));
      check_eq("mw_en",        32'(mw_en),        32'(e.mw_en));
      check_eq("mw_bubble",    32'(mw_bubble),    32'(e.mw_bubble));
      check_eq("muldiv_start", 32'(muldiv_start), 32'(e.start));
      check_eq("muldiv_busy",  32'(muldiv_busy),  32'(e.busy));
      check_eq("mem_error",    32'(mem_error),    32'(e.err));
      check_eq("stall_cycles", stall_cycles,      e.stall);
    end
  end

  initial begin
    rst = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_muldiv = 0; id_reads_hilo = 0; ex_mem_read = 0; ex_reg_write = 0;
    ex_write_reg_addr = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    last = '0;
    repeat (2) @(posedge clk);

    // Reset-held cycles, then normal idle
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load-use on rt, on rs, and against r0 (no stall)
    apply(1, 0, 5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 0);
    idle(1);
    apply(1, 7, 0, 1, 0, 0, 0, 1, 1, 7, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 5, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0); // rt matches but unused
    idle(1);

    // Memory wait of 3 cycles, release, then a single-cycle access
    mem(1, 0); mem(1, 0); mem(1, 0); mem(1, 1);
    idle(1);
    mem(1, 1);
    idle(1);

    // Mult/div launch, then mfhi stalls until the unit is free
    apply(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) apply(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Branch beats load-use; freeze beats branch
    apply(1, 0, 5, 0, 1, 0, 0, 1, 1, 5, 1, 0, 0);
    apply(1, 0, 5, 0, 1, 0, 0, 1, 1, 5, 1, 1, 0);
    mem(1, 1);
    idle(1);

    // Saturation of the stall counter
    @(posedge clk);
    model_tick(last);
    #1;
    force dut.stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles;
    m_stall = 64'hFFFF_FFFD;
    last = model_out();
    q.push_back(last);
    mem(1, 0); mem(1, 0); mem(1, 0); mem(1, 1);
    idle(1);

    // Reset in the middle of a memory wait
    mem(1, 0); mem(1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Timeout into HALT, stay halted, then reset out of it
    repeat (6) mem(1, 0);
    idle(2);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    repeat (3) @(negedge clk);
    check_eq("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
